// File: rtl/divider_multi.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero dividend in one step.
module divider_multi #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [1:0]      div_func,
    input  logic            start,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam int unsigned     CW       = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      func_q;
    logic [XLEN-1:0] a_q, dvs_q, quo_q, rem_q, result_q;
    logic            neg_quo_q, neg_rem_q, div0_q, ovf_q, early_q, done_q, busy_q;

    logic            accept_d, sgn_d, a_neg_d, b_neg_d, div0_d, ovf_d, early_d, qbit_d;
    logic [XLEN-1:0] a_mag_d, b_mag_d, rem_d, quo_d, q_fin_d, r_fin_d, result_d;
    logic [XLEN:0]   rem_w_d, diff_d;

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

    always_comb begin
        accept_d = start && (state_q != BUSY);
        sgn_d    = ~div_func[0];
        a_neg_d  = sgn_d & dividend[XLEN-1];
        b_neg_d  = sgn_d & divisor[XLEN-1];
        a_mag_d  = a_neg_d ? (~dividend + 1'b1) : dividend;
        b_mag_d  = b_neg_d ? (~divisor + 1'b1) : divisor;
        div0_d   = (divisor == '0);
        ovf_d    = sgn_d && (dividend == MOST_NEG) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
        early_d  = div0_d || ovf_d || (dividend == '0);
`else
        early_d  = 1'b0;
`endif
    end

    // Remainder and remaining dividend bits share one shift path: {rem_q, quo_q}.
    always_comb begin
        rem_w_d = {rem_q, quo_q[XLEN-1]};
        diff_d  = rem_w_d - {1'b0, dvs_q};
        qbit_d  = ~diff_d[XLEN];
        rem_d   = qbit_d ? diff_d[XLEN-1:0] : rem_w_d[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], qbit_d};
    end

    // A zero dividend needs no override: quo_q/rem_q already hold 0 from acceptance.
    always_comb begin
        q_fin_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        r_fin_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (div0_q) begin
            q_fin_d = '1;
            r_fin_d = a_q;
        end else if (ovf_q) begin
            q_fin_d = a_q;
            r_fin_d = '0;
        end
        result_d = func_q[1] ? r_fin_d : q_fin_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            func_q    <= '0;
            a_q       <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            early_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept_d) begin
                        state_q   <= BUSY;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        func_q    <= div_func;
                        a_q       <= dividend;
                        quo_q     <= a_mag_d;
                        dvs_q     <= b_mag_d;
                        neg_quo_q <= a_neg_d ^ b_neg_d;
                        neg_rem_q <= a_neg_d;
                        div0_q    <= div0_d;
                        ovf_q     <= ovf_d;
                        early_q   <= early_d;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (early_q || (cnt_q == CW'(XLEN))) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_multi.sv
// Scoreboard bench for divider_multi: driver pushes model results, negedge monitor pops and compares.
module tb_divider_multi;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MN   = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [1:0]  div_func = '0;
    logic        start = 1'b0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    divider_multi #(.XLEN(XLEN)) dut (
        .clock    (clock),
        .reset    (reset),
        .dividend (dividend),
        .divisor  (divisor),
        .div_func (div_func),
        .start    (start),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
        int unsigned s;
        int unsigned lat;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        int  sa;
        int  sbv;
        bit  ovf;
        sa  = a;
        sbv = b;
        ovf = (a == MN) && (b == 32'hFFFF_FFFF);
        case (f)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || a == 0 || (!f[0] && a == MN && b == 32'hFFFF_FFFF)) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Monitor: result, latency, single-cycle done, and result stability between completions.
    logic        prev_done = 1'b0;
    logic [31:0] last_res  = '0;
    always @(negedge clock) begin
        if (reset) begin
            prev_done = 1'b0;
            last_res  = '0;
        end else begin
            if (done) begin
                check("done_width", {31'b0, prev_done}, 32'h0);
                if (scb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 result=%h, expected no pending op (cycle %0d)", result, cyc);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    check($sformatf("result f=%0d a=%h b=%h", e.f, e.a, e.b), result, e.res);
                    check("latency", cyc - e.s, e.lat);
                    last_res = e.res;
                end
            end else begin
                check("result_hold", result, last_res);
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f, input bit expect_it);
        exp_t e;
        dividend = a;
        divisor  = b;
        div_func = f;
        start    = 1'b1;
        if (expect_it) begin
            e.res = model(a, b, f);
            e.a   = a;
            e.b   = b;
            e.f   = f;
            e.s   = cyc + 1;
            e.lat = latency(a, b, f);
            scb.push_back(e);
        end
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        div_func = 2'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", n);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return MN;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
    } op_t;

    op_t dir[$] = '{
        '{32'd100,       32'd7,          2'b01},
        '{32'd100,       32'd7,          2'b11},
        '{32'hFFFF_FFF9, 32'd2,          2'b00},
        '{32'hFFFF_FFF9, 32'd2,          2'b10},
        '{32'd7,         32'hFFFF_FFFE,  2'b10},
        '{32'd5,         32'd0,          2'b01},
        '{32'd5,         32'd0,          2'b11},
        '{MN,            32'hFFFF_FFFF,  2'b00},
        '{MN,            32'hFFFF_FFFF,  2'b10},
        '{32'hFFFF_FFFB, 32'd0,          2'b00},
        '{32'hFFFF_FFFB, 32'd0,          2'b10},
        '{32'd0,         32'd9,          2'b00}
    };

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_result", result, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        foreach (dir[i]) begin
            issue(dir[i].a, dir[i].b, dir[i].f, 1'b1);
            check("busy_in_flight", {31'b0, busy}, 32'h1);
            wait_done();
            @(negedge clock);
        end

        // A start during BUSY must be ignored; then a back-to-back start in the DONE cycle.
        issue(32'd1000, 32'd10, 2'b01, 1'b1);
        repeat (5) @(negedge clock);
        issue(32'd9, 32'd3, 2'b01, 1'b0);
        wait_done();
        issue(32'd9, 32'd3, 2'b01, 1'b1);
        wait_done();
        repeat (40) @(negedge clock);

        // Asynchronous reset mid-operation.
        issue(32'hFFFF_FFFF, 32'd3, 2'b01, 1'b1);
        repeat (8) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_result", result, 32'h0);
        check("async_reset_done", {31'b0, done}, 32'h0);
        check("async_reset_busy", {31'b0, busy}, 32'h0);
        scb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        issue(32'd81, 32'd9, 2'b01, 1'b1);
        wait_done();
        @(negedge clock);

        for (int i = 0; i < 200; i++) begin
            issue(pick(), pick(), 2'($urandom), 1'b1);
            wait_done();
            if ($urandom % 2 == 0) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(scb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
